// File: rtl/regfile_wb_pkg.sv
// Shared constants, FIFO entry payload and sizing helper for the register-file write arbiter.
package regfile_wb_pkg;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned ADD_WIDTH = 5;
  localparam int unsigned NUM_REGS  = 2 ** ADD_WIDTH;

  typedef struct packed {
    logic                 live;
    logic [ADD_WIDTH-1:0] addr;
    logic [WIDTH-1:0]     data;
  } wb_entry_t;

  // Occupancy counter width: must be able to hold FIFO_DEPTH itself.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of pipeline writeback, long-latency handshake, register-file write port and status signals.
interface regfile_wb_arbiter_if
  import regfile_wb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);

  logic                 PIPE_WB_VALID;
  logic [ADD_WIDTH-1:0] PIPE_WB_ADDR;
  logic [WIDTH-1:0]     PIPE_WB_DATA;
  logic                 LL_VALID;
  logic                 LL_READY;
  logic [ADD_WIDTH-1:0] LL_ADDR;
  logic [WIDTH-1:0]     LL_DATA;
  logic                 WRITE_ENABLE;
  logic [ADD_WIDTH-1:0] ADDRESS_3;
  logic [WIDTH-1:0]     WRITE_DATA;
  logic [CNT_W-1:0]     FIFO_COUNT;
  logic [NUM_REGS-1:0]  PENDING_MASK;

  // Arbiter side: owns the register-file write port.
  modport master (
    input  PIPE_WB_VALID, PIPE_WB_ADDR, PIPE_WB_DATA,
    input  LL_VALID, LL_ADDR, LL_DATA,
    output LL_READY,
    output WRITE_ENABLE, ADDRESS_3, WRITE_DATA,
    output FIFO_COUNT, PENDING_MASK
  );

  // Producer / register-file / hazard-unit side.
  modport slave (
    output PIPE_WB_VALID, PIPE_WB_ADDR, PIPE_WB_DATA,
    output LL_VALID, LL_ADDR, LL_DATA,
    input  LL_READY,
    input  WRITE_ENABLE, ADDRESS_3, WRITE_DATA,
    input  FIFO_COUNT, PENDING_MASK
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Long-latency result buffer: circular storage with per-entry squash compare and pending-write mask.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
)(
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic                                   push,
  input  wb_entry_t                              push_entry,
  input  logic                                   pop,
  input  logic                                   squash,
  input  logic [ADD_WIDTH-1:0]                   squash_addr,
  output wb_entry_t                              head,
  output logic [cnt_width(FIFO_DEPTH)-1:0]       count,
  output logic                                   full,
  output logic                                   empty,
  output logic [NUM_REGS-1:0]                    pending_mask
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);

  wb_entry_t        mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;

  // Squash, then retire the popped slot, then write the new entry; later assignments win.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[PTR_W'(i)].live <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        if (squash && (mem[PTR_W'(i)].addr == squash_addr)) begin
          mem[PTR_W'(i)].live <= 1'b0;
        end
      end
      if (pop) begin
        mem[rd_ptr].live <= 1'b0;
        rd_ptr           <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  // Free slots have live=0, so only queued, unsquashed writes contribute.
  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (mem[PTR_W'(i)].live) begin
        pending_mask[mem[PTR_W'(i)].addr] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency results queue and drain.
// Optional same-cycle long-latency write when the queue is empty: define WB_FIFO_BYPASS_EN.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
)(
  input  logic                 CLK,
  input  logic                 RESET,
  regfile_wb_arbiter_if.master bus
);

  localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);

  wb_entry_t           head;
  wb_entry_t           push_entry;
  logic                pipe_act;
  logic                ll_ready;
  logic                ll_fire;
  logic                ll_nz;
  logic                bypass;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [CNT_W-1:0]    count;
  logic [NUM_REGS-1:0] pending_mask;

  assign pipe_act = bus.PIPE_WB_VALID && (bus.PIPE_WB_ADDR != '0);
  assign ll_ready = !RESET && !full;
  assign ll_fire  = bus.LL_VALID && ll_ready;
  assign ll_nz    = (bus.LL_ADDR != '0);

`ifdef WB_FIFO_BYPASS_EN
  assign bypass = empty && !pipe_act && ll_fire && ll_nz;
`else
  assign bypass = 1'b0;
`endif

  // x0 results complete the handshake but are dropped; a same-address pipeline write makes them dead on arrival.
  assign push = ll_fire && ll_nz && !bypass;
  assign pop  = !RESET && !empty && !pipe_act;

  assign push_entry.live = !(pipe_act && (bus.LL_ADDR == bus.PIPE_WB_ADDR));
  assign push_entry.addr = bus.LL_ADDR;
  assign push_entry.data = bus.LL_DATA;

  wb_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_wb_fifo (
    .CLK          (CLK),
    .RESET        (RESET),
    .push         (push),
    .push_entry   (push_entry),
    .pop          (pop),
    .squash       (pipe_act),
    .squash_addr  (bus.PIPE_WB_ADDR),
    .head         (head),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .pending_mask (pending_mask)
  );

  // Write-port select; combinational so pipeline results reach the file with no added latency.
  always_comb begin
    bus.WRITE_ENABLE = 1'b0;
    bus.ADDRESS_3    = '0;
    bus.WRITE_DATA   = '0;
    if (!RESET) begin
      if (pipe_act) begin
        bus.WRITE_ENABLE = 1'b1;
        bus.ADDRESS_3    = bus.PIPE_WB_ADDR;
        bus.WRITE_DATA   = bus.PIPE_WB_DATA;
      end else if (!empty) begin
        if (head.live) begin
          bus.WRITE_ENABLE = 1'b1;
          bus.ADDRESS_3    = head.addr;
          bus.WRITE_DATA   = head.data;
        end
      end else if (bypass) begin
        bus.WRITE_ENABLE = 1'b1;
        bus.ADDRESS_3    = bus.LL_ADDR;
        bus.WRITE_DATA   = bus.LL_DATA;
      end
    end
  end

  assign bus.LL_READY     = ll_ready;
  assign bus.FIFO_COUNT   = count;
  assign bus.PENDING_MASK = pending_mask;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand sequences and random stimulus against a queue model.
module tb_regfile_wb_arbiter;

  localparam int unsigned DEPTH = 4;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  regfile_wb_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus ();

  regfile_wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.master)
  );

  typedef struct {
    bit          live;
    logic [4:0]  a;
    logic [31:0] d;
  } m_t;

  typedef struct {
    bit          rst;
    bit          pv;
    logic [4:0]  pa;
    logic [31:0] pd;
    bit          lv;
    logic [4:0]  la;
    logic [31:0] ld;
    bit          x_rdy;
    bit          x_we;
    logic [4:0]  x_a;
    logic [31:0] x_d;
    logic [31:0] x_cnt;
    logic [31:0] x_mask;
    bit          chk_st;
  } vec_t;

  m_t   mq[$];
  vec_t vq[$];
  bit   synced = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic        a_rdy, a_we;
  logic [4:0]  a_a;
  logic [31:0] a_d, a_cnt, a_mask;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check outputs against the queue model, then advance the model.
  task automatic cycle(input bit rst, input bit pv, input logic [4:0] pa, input logic [31:0] pd,
                       input bit lv, input logic [4:0] la, input logic [31:0] ld);
    bit          e_rdy, e_we, pact, fire, byp;
    logic [4:0]  e_a;
    logic [31:0] e_d, e_mask;
    @(negedge CLK);
    RESET             = rst;
    bus.PIPE_WB_VALID = pv;
    bus.PIPE_WB_ADDR  = pa;
    bus.PIPE_WB_DATA  = pd;
    bus.LL_VALID      = lv;
    bus.LL_ADDR       = la;
    bus.LL_DATA       = ld;
    #1;
    a_rdy  = bus.LL_READY;
    a_we   = bus.WRITE_ENABLE;
    a_a    = bus.ADDRESS_3;
    a_d    = bus.WRITE_DATA;
    a_cnt  = 32'(bus.FIFO_COUNT);
    a_mask = bus.PENDING_MASK;

    pact  = pv && (pa != 5'd0);
    e_rdy = !rst && (mq.size() < DEPTH);
    fire  = lv && e_rdy;
    byp   = 1'b0;
`ifdef WB_FIFO_BYPASS_EN
    byp = (mq.size() == 0) && !pact && fire && (la != 5'd0);
`endif
    e_we = 1'b0; e_a = '0; e_d = '0;
    if (!rst) begin
      if (pact) begin
        e_we = 1'b1; e_a = pa; e_d = pd;
      end else if (mq.size() > 0) begin
        if (mq[0].live) begin e_we = 1'b1; e_a = mq[0].a; e_d = mq[0].d; end
      end else if (byp) begin
        e_we = 1'b1; e_a = la; e_d = ld;
      end
    end
    e_mask = '0;
    foreach (mq[i]) if (mq[i].live) e_mask[mq[i].a] = 1'b1;

    chk("ll_ready", 32'(a_rdy), 32'(e_rdy));
    chk("write_enable", 32'(a_we), 32'(e_we));
    chk("x0_write", 32'(a_we && (a_a == 5'd0)), 32'd0);
    if (e_we) begin
      chk("address_3", 32'(a_a), 32'(e_a));
      chk("write_data", a_d, e_d);
    end
    if (synced) begin
      chk("fifo_count", a_cnt, 32'(mq.size()));
      chk("pending_mask", a_mask, e_mask);
    end

    if (rst) begin
      mq.delete();
      synced = 1'b1;
    end else begin
      if (pact) foreach (mq[i]) if (mq[i].a == pa) mq[i].live = 1'b0;
      if (!pact && (mq.size() > 0)) void'(mq.pop_front());
      if (fire && (la != 5'd0) && !byp) mq.push_back('{live: !(pact && (la == pa)), a: la, d: ld});
    end
  endtask

  task automatic add(input bit rst, input bit pv, input logic [4:0] pa, input logic [31:0] pd,
                     input bit lv, input logic [4:0] la, input logic [31:0] ld,
                     input bit x_rdy, input bit x_we, input logic [4:0] x_a, input logic [31:0] x_d,
                     input logic [31:0] x_cnt, input logic [31:0] x_mask, input bit chk_st);
    vq.push_back('{rst, pv, pa, pd, lv, la, ld, x_rdy, x_we, x_a, x_d, x_cnt, x_mask, chk_st});
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    // Reset with an offered result, then basic drain.
    add(1, 0, 0, 0, 1, 4, 32'h4444, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 4, 32'h4444, 0, 0, 0, 0, 0, 0, 1);
`ifdef WB_FIFO_BYPASS_EN
    add(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 1, 1, 5, 32'hDEADBEEF, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0,            1, 0, 0, 0, 0, 0, 1);
`else
    add(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0,            1, 1, 5, 32'hDEADBEEF, 1, 32'h20, 1);
`endif
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    // Pipeline owns the port while the queue fills to DEPTH.
    add(0, 1, 3, 32'h33, 1,  8, 32'h80, 1, 1, 3, 32'h33, 0, 32'h000, 1);
    add(0, 1, 3, 32'h33, 1,  9, 32'h90, 1, 1, 3, 32'h33, 1, 32'h100, 1);
    add(0, 1, 3, 32'h33, 1, 10, 32'hA0, 1, 1, 3, 32'h33, 2, 32'h300, 1);
    add(0, 1, 3, 32'h33, 1, 11, 32'hB0, 1, 1, 3, 32'h33, 3, 32'h700, 1);
    add(0, 1, 3, 32'h33, 1, 12, 32'hC0, 0, 1, 3, 32'h33, 4, 32'hF00, 1);
    // Pipe drops: four queued writes drain in acceptance order.
    add(0, 0, 0, 0, 0, 0, 0, 0, 1,  8, 32'h80, 4, 32'hF00, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1,  9, 32'h90, 3, 32'hE00, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 10, 32'hA0, 2, 32'hC00, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 11, 32'hB0, 1, 32'h800, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 32'h0,  0, 32'h000, 1);

    foreach (vq[k]) begin
      cycle(vq[k].rst, vq[k].pv, vq[k].pa, vq[k].pd, vq[k].lv, vq[k].la, vq[k].ld);
      chk($sformatf("vec%0d_ready", k), 32'(a_rdy), 32'(vq[k].x_rdy));
      chk($sformatf("vec%0d_we", k), 32'(a_we), 32'(vq[k].x_we));
      if (vq[k].x_we) begin
        chk($sformatf("vec%0d_addr", k), 32'(a_a), 32'(vq[k].x_a));
        chk($sformatf("vec%0d_data", k), a_d, vq[k].x_d);
      end
      if (vq[k].chk_st) begin
        chk($sformatf("vec%0d_count", k), a_cnt, vq[k].x_cnt);
        chk($sformatf("vec%0d_mask", k), a_mask, vq[k].x_mask);
      end
    end

    // Squash: queued 7<-1 overtaken by pipeline 7<-2.
    cycle(0, 1, 2, 32'h22, 1, 7, 32'd1);
    cycle(0, 1, 7, 32'd2, 0, 0, 0);
    chk("squash_pipe_we", 32'(a_we), 32'd1);
    chk("squash_pipe_addr", 32'(a_a), 32'd7);
    chk("squash_pipe_data", a_d, 32'd2);
    chk("squash_mask_before", 32'(a_mask[7]), 32'd1);
    idle();
    chk("squash_dead_we", 32'(a_we), 32'd0);
    chk("squash_dead_count", a_cnt, 32'd1);
    chk("squash_mask_after", 32'(a_mask[7]), 32'd0);
    idle();
    chk("squash_popped", a_cnt, 32'd0);
    chk("squash_no_stale", 32'(a_we), 32'd0);
    // Same-cycle squash of an incoming result.
    cycle(0, 1, 9, 32'h99, 1, 9, 32'h98);
    idle();
    chk("sq_in_dead_we", 32'(a_we), 32'd0);
    chk("sq_in_count", a_cnt, 32'd1);
    chk("sq_in_mask", a_mask, 32'd0);
    idle();

    // x0: dropped handshake, and pipe addr 0 lets the queue drain.
    cycle(0, 0, 0, 0, 1, 0, 32'h55);
    chk("x0_ll_ready", 32'(a_rdy), 32'd1);
    idle();
    chk("x0_ll_count", a_cnt, 32'd0);
    chk("x0_ll_we", 32'(a_we), 32'd0);
    cycle(0, 1, 4, 32'h44, 1, 6, 32'h66);
    cycle(0, 1, 0, 32'hAA, 0, 0, 0);
    chk("x0_pipe_drain_we", 32'(a_we), 32'd1);
    chk("x0_pipe_drain_addr", 32'(a_a), 32'd6);
    chk("x0_pipe_drain_data", a_d, 32'h66);
    idle();
    chk("x0_pipe_drained", a_cnt, 32'd0);

    // Reset mid-drain discards three live entries.
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 32'h11, 1, 5'(12 + i), 32'(i));
    cycle(1, 0, 0, 0, 0, 0, 0);
    chk("rst_mid_we", 32'(a_we), 32'd0);
    chk("rst_mid_pre_count", a_cnt, 32'd3);
    idle();
    chk("rst_mid_count", a_cnt, 32'd0);
    chk("rst_mid_mask", a_mask, 32'd0);
    chk("rst_mid_we_after", 32'(a_we), 32'd0);
    idle();
    chk("rst_mid_no_stale", 32'(a_we), 32'd0);

    // Random traffic with narrow address range for frequent collisions.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
